// File: rtl/circular_buffer_reader.sv
// Read-side sequencer for the circular sample buffer: sweeps all entries oldest-first,
// reading RAM with a fixed latency and presenting each sample on a valid/ready stream.
module circular_buffer_reader #(
  parameter int unsigned BUF_LEN = 800,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned REL_W   = 10,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic              r_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] oldest_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] sample,
  output logic [REL_W-1:0]  sample_idx,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              sample_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StPresent, StFin} state_e;

  localparam logic [ADDR_W:0]   BufLenWide = (ADDR_W + 1)'(BUF_LEN);
  localparam logic [ADDR_W-1:0] BufLenAddr = ADDR_W'(BUF_LEN);
  localparam logic [REL_W-1:0]  LastRel    = REL_W'(BUF_LEN - 1);
  localparam logic [1:0]        WaitInit   = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [REL_W-1:0]  rel_q, rel_d;
  logic [1:0]        wait_q, wait_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [REL_W-1:0]  idx_q, idx_d;
  logic [ADDR_W:0]   addr_sum, addr_wrap;

  // One extra bit so base+rel cannot overflow before the wrap subtraction.
  assign addr_sum  = {1'b0, base_q} + (ADDR_W + 1)'(rel_q);
  assign addr_wrap = (addr_sum >= BufLenWide) ? addr_sum - BufLenWide : addr_sum;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    rel_d     = rel_q;
    wait_d    = wait_q;
    sample_d  = sample_q;
    idx_d     = idx_q;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = (oldest_addr >= BufLenAddr) ? '0 : oldest_addr;
          rel_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(addr_wrap);
        wait_d    = WaitInit;
        state_d   = StWait;
      end
      StWait: begin
        if (wait_q == 2'd0) begin
          sample_d = mem_data;
          idx_d    = rel_q;
          state_d  = StPresent;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      StPresent: begin
        if (sample_ready) begin
          if (rel_q == LastRel) begin
            state_d = StFin;
          end else begin
            rel_d   = rel_q + REL_W'(1);
            state_d = StIssue;
          end
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      rel_q    <= '0;
      wait_q   <= '0;
      sample_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      rel_q    <= rel_d;
      wait_q   <= wait_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
    end
  end

  assign sample       = sample_q;
  assign sample_idx   = idx_q;
  assign sample_valid = (state_q == StPresent);
  assign sample_last  = sample_valid && (idx_q == LastRel);
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_circular_buffer_reader.sv
// Scoreboard bench: two readers (RD_LAT 1 and 3) share stimulus; each has its own RAM model
// and a monitor that checks every handshake against a queue filled when a start is accepted.
module tb_circular_buffer_reader;

  localparam int BUF_LEN = 800;
  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 15;
  localparam int REL_W   = 10;

  typedef struct {
    int addr;
    int val;
    int idx;
    bit last;
  } exp_t;

  logic              r_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] oldest_addr = '0;
  logic              sample_ready = 1'b1;
  int                ready_mode = 0;

  logic              rd_en_w [2];
  logic [ADDR_W-1:0] addr_w  [2];
  logic [DATA_W-1:0] rdata_w [2];
  logic [DATA_W-1:0] smp_w   [2];
  logic [REL_W-1:0]  idx_w   [2];
  logic              valid_w [2];
  logic              last_w  [2];
  logic              busy_w  [2];
  logic              done_w  [2];

  logic [DATA_W-1:0] mem [BUF_LEN];

  int vectors = 0;
  int miscompares = 0;

  always #5 r_clk = ~r_clk;

  task automatic check(input int d, input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL dut%0d %s: got %0d, expected %0d", d, name, act, exp);
    end
  endtask

  // Mode 0: ready high, 1: random ~80% high, 2: held low.
  always @(posedge r_clk) begin
    #2;
    case (ready_mode)
      1:       sample_ready = ($urandom_range(0, 4) != 0);
      2:       sample_ready = 1'b0;
      default: sample_ready = 1'b1;
    endcase
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : 3;

    logic [DATA_W-1:0] pipe [L];
    exp_t q[$];
    int   cyc = 0;
    int   ref_cyc = 0;
    int   reads = 0;
    bit   m_busy = 0;
    bit   m_fin = 0;
    bit   prev_valid = 0;

    circular_buffer_reader #(
      .BUF_LEN(BUF_LEN),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .REL_W  (REL_W),
      .RD_LAT (L)
    ) u_dut (
      .r_clk       (r_clk),
      .rst_n       (rst_n),
      .start       (start),
      .oldest_addr (oldest_addr),
      .mem_rd_en   (rd_en_w[g]),
      .mem_addr    (addr_w[g]),
      .mem_data    (rdata_w[g]),
      .sample      (smp_w[g]),
      .sample_idx  (idx_w[g]),
      .sample_valid(valid_w[g]),
      .sample_ready(sample_ready),
      .sample_last (last_w[g]),
      .busy        (busy_w[g]),
      .done        (done_w[g])
    );

    // RAM model: data appears L cycles after the read strobe, garbage otherwise.
    always @(posedge r_clk) begin
      pipe[0] <= rd_en_w[g] ? mem[int'(addr_w[g]) % BUF_LEN] : DATA_W'($urandom);
      for (int k = 1; k < int'(L); k++) pipe[k] <= pipe[k-1];
    end
    assign rdata_w[g] = pipe[L-1];

    always @(negedge r_clk) begin
      bit   nfin;
      bit   nbusy;
      int   b;
      exp_t e;
      cyc++;
      if (!rst_n) begin
        check(g, "reset_outputs", longint'({rd_en_w[g], addr_w[g], smp_w[g], idx_w[g],
              valid_w[g], last_w[g], busy_w[g], done_w[g]}), 0);
        q.delete();
        m_busy = 0;
        m_fin = 0;
        prev_valid = 0;
        reads = 0;
      end else begin
        nfin = 0;
        nbusy = m_busy;
        check(g, "busy", busy_w[g], m_busy);
        check(g, "done", done_w[g], m_fin);
        if (rd_en_w[g]) begin
          if (q.size() == 0) check(g, "rd_en_idle", rd_en_w[g], 0);
          else begin
            check(g, "mem_addr", addr_w[g], q[0].addr);
            reads++;
          end
        end
        if (valid_w[g]) begin
          if (q.size() == 0) check(g, "valid_idle", valid_w[g], 0);
          else begin
            check(g, "sample", smp_w[g], q[0].val);
            check(g, "sample_idx", idx_w[g], q[0].idx);
            check(g, "sample_last", last_w[g], q[0].last);
            check(g, "rd_en_while_presenting", rd_en_w[g], 0);
            if (!prev_valid) check(g, "latency", cyc - ref_cyc, 2 + int'(L));
            if (sample_ready) begin
              check(g, "reads_per_sample", reads, 1);
              reads = 0;
              ref_cyc = cyc;
              if (q[0].last) nfin = 1;
              void'(q.pop_front());
            end
          end
        end else begin
          check(g, "last_without_valid", last_w[g], 0);
        end
        if (m_fin) nbusy = 0;
        if (start && !m_busy) begin
          b = (int'(oldest_addr) >= BUF_LEN) ? 0 : int'(oldest_addr);
          for (int k = 0; k < BUF_LEN; k++) begin
            e.addr = (b + k) % BUF_LEN;
            e.val  = int'(mem[e.addr]);
            e.idx  = k;
            e.last = (k == BUF_LEN - 1);
            q.push_back(e);
          end
          ref_cyc = cyc;
          reads = 0;
          nbusy = 1;
        end
        m_busy = nbusy;
        m_fin = nfin;
        prev_valid = valid_w[g];
      end
    end
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic pulse(input int addr);
    oldest_addr = ADDR_W'(addr);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 20000; i++) begin
      if (!busy_w[0] && !busy_w[1]) break;
      tick();
    end
    if (i == 20000) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: sweep did not finish within 20000 cycles");
    end
  endtask

  task automatic wait_idx(input int n);
    int i;
    for (i = 0; i < 20000; i++) begin
      if (valid_w[0] && int'(idx_w[0]) == n) break;
      tick();
    end
    if (i == 20000) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idx: index %0d never presented", n);
    end
  endtask

  task automatic sweep_len_check();
    int n;
    for (n = 0; n < 5000; n++) begin
      if (done_w[0]) break;
      tick();
    end
    check(0, "sweep_len", n, 2400);
  endtask

  initial begin
    for (int i = 0; i < BUF_LEN; i++) mem[i] = DATA_W'($urandom);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Aligned sweep, ready high; first ISSUE to FIN is 2400 cycles for RD_LAT=1.
    pulse(0);
    sweep_len_check();
    wait_idle();

    pulse(795);
    wait_idle();

    // Ten-cycle stall at idx 3, then random backpressure.
    pulse(300);
    wait_idx(3);
    ready_mode = 2;
    repeat (10) tick();
    ready_mode = 1;
    wait_idle();

    // Restart attempt mid-sweep with a new oldest address must be ignored.
    ready_mode = 0;
    pulse(0);
    wait_idx(100);
    pulse(50);
    wait_idle();

    pulse(799);
    wait_idle();
    pulse(1000);
    wait_idle();

    // Asynchronous reset while presenting idx 5.
    pulse(123);
    wait_idx(5);
    rst_n = 1'b0;
    #1;
    check(0, "async_reset_valid", valid_w[0], 0);
    check(1, "async_reset_busy", busy_w[1], 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pulse(0);
    wait_idle();

    // Start coinciding with FIN must be ignored.
    pulse(7);
    for (int i = 0; i < 5000; i++) begin
      if (done_w[0]) break;
      tick();
    end
    start = 1'b1;
    oldest_addr = ADDR_W'(400);
    tick();
    start = 1'b0;
    wait_idle();
    check(0, "idle_after_fin_start", busy_w[0], 0);

    ready_mode = 1;
    for (int s = 0; s < 2; s++) begin
      pulse(int'($urandom_range(0, 1199)));
      wait_idle();
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/circular_buffer_reader.md
Name: circular_buffer_reader

Overview:
Read-side sequencer for the 800-entry circular sample buffer. On a start pulse it snapshots the oldest-sample address and sweeps relative indices 0..BUF_LEN-1. For each index it computes the wrapped absolute address, issues a synchronous memory read, and presents the sample on a valid/ready stream. Sits between the sample RAM read port and the display/trace renderer, so samples reach the display in chronological order, oldest first.

Parameters:
BUF_LEN, 800, buffer depth in samples; also the number of samples per sweep.
DATA_W, 12, sample width.
ADDR_W, 15, absolute RAM address width.
REL_W, 10, relative index width; must satisfy 2^REL_W >= BUF_LEN.
RD_LAT, 1, RAM read latency in r_clk cycles (legal values 1..3).

Ports:
r_clk  in  1  single clock; all logic on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins a sweep. Ignored unless the FSM is in IDLE.
oldest_addr  in  ADDR_W  absolute address of the oldest sample; sampled only on an accepted start.
mem_rd_en  out  1  RAM read strobe.
mem_addr  out  ADDR_W  RAM read address.
mem_data  in  DATA_W  RAM read data; valid RD_LAT cycles after mem_rd_en.
sample  out  DATA_W  output sample.
sample_idx  out  REL_W  relative index of sample (0 = oldest).
sample_valid  out  1  sample/sample_idx valid.
sample_ready  in  1  downstream accepts when high together with sample_valid.
sample_last  out  1  high with sample_valid when sample_idx == BUF_LEN-1.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (async assert, release synchronous to r_clk): state=IDLE. All outputs 0: mem_rd_en, mem_addr, sample, sample_idx, sample_valid, sample_last, busy, done. Internal base and relative counter are 0.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, FIN.
- IDLE:
  - start=1: base <= (oldest_addr >= BUF_LEN) ? 0 : oldest_addr; rel <= 0; go to ISSUE.
  - start=0: stay in IDLE.
- ISSUE (one cycle):
  - mem_rd_en=1.
  - mem_addr = base+rel; if the sum >= BUF_LEN, subtract BUF_LEN. Compute the sum at ADDR_W+1 bits so it cannot overflow.
  - Load the wait counter with RD_LAT-1, then go to WAIT. mem_rd_en is high for exactly one cycle per sample.
- WAIT:
  - Decrement the wait counter each cycle.
  - When the counter is 0 and the data cycle is reached, register sample <= mem_data and sample_idx <= rel, then go to PRESENT.
  - With RD_LAT=1, WAIT lasts one cycle.
- PRESENT:
  - sample_valid=1. sample, sample_idx and sample_last are held stable until the handshake.
  - On handshake with rel < BUF_LEN-1: rel <= rel+1, go to ISSUE.
  - On handshake with rel == BUF_LEN-1: go to FIN.
  - sample_valid drops the cycle after the handshake.
- FIN: done=1 for one cycle; go to IDLE. busy drops in the cycle after FIN.
- Latency and throughput:
  - start to first sample_valid = 2+RD_LAT cycles (3 with RD_LAT=1).
  - With sample_ready tied high, one sample every 2+RD_LAT cycles.
  - A full sweep with RD_LAT=1 and sample_ready tied high takes 2400 cycles from first ISSUE to FIN.
- Wrap-around: the absolute address wraps exactly once per sweep at rel = BUF_LEN-base (never when base=0).
- Boundaries:
  - start while busy: ignored; no restart and the base is not updated.
  - start in the same cycle as FIN: ignored.
  - Backpressure: sample_ready held low stalls indefinitely in PRESENT. No further RAM reads occur during the stall.
  - rst_n asserted mid-sweep: immediate return to reset values; no done pulse.
  - oldest_addr >= BUF_LEN at start: the snapshot clamps to 0.

Test Plan:
- Reset mid-PRESENT at rel=5 -> all outputs 0 asynchronously; state=IDLE; the next start sweeps from rel=0.
- RAM preloaded with mem[i]=i; oldest_addr=0; start; sample_ready=1 -> samples 0..799 in order with sample_idx=value; sample_last only at idx 799; done exactly once, 2400 cycles after the first ISSUE; mem_rd_en pulses = 800.
- oldest_addr=795, same RAM -> samples 795,796,797,798,799,0,1,...,794; mem_addr never >= 800; wrap occurs at idx 5.
- oldest_addr=300; sample_ready low for 10 cycles at idx 3 -> sample=303 and idx=3 held stable for all 10 cycles; no mem_rd_en during the stall; the sweep completes normally.
- Second start pulse at idx 100, with oldest_addr changed to 50 -> ignored; samples continue 101.. from the original base; done once.
- RD_LAT=3 build, oldest_addr=799 -> first sample 799 arrives 5 cycles after start; second sample is 0; period is 5 cycles; oldest_addr=1000 -> treated as base 0.
